// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: status bit positions,
// the empty-read value and the status byte packer.
package uart_rx_ctrl_pkg;

  localparam int STAT_AVAIL = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_BUSY  = 3;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  function automatic logic [7:0] make_status(input logic not_empty,
                                             input logic is_full,
                                             input logic ovr,
                                             input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_AVAIL] = not_empty;
    s[STAT_FULL]  = is_full;
    s[STAT_OVR]   = ovr;
    s[STAT_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module uart_rx_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [0:(1 << AW) - 1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud tick, rxd synchroniser, byte capture into the
// FIFO, sticky overrun flag and the data/status read port for the CPU.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 15,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       core_rxIN,
  output logic       core_tick,
  input  logic [7:0] core_byte,
  input  logic       core_ready,
  input  logic       core_avail,
  input  logic       rd_data,
  input  logic       rd_status,
  output logic [7:0] dout
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        rx_s1;
  logic        rx_s2;
  logic [15:0] baud_cnt;
  logic        avail_q;
  logic        avail_prev;
  logic        push_req;
  logic        overrun;
  logic        ovr_set;
  logic [7:0]  fifo_head;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  status_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  assign core_rxIN = rx_s2;

  always_ff @(posedge clk) begin
    if (reset)                     baud_cnt <= '0;
    else if (baud_cnt == DIV_LAST) baud_cnt <= '0;
    else                           baud_cnt <= baud_cnt + 16'd1;
  end

  assign core_tick = (baud_cnt == DIV_LAST);

  // core_avail is registered first, then edge-detected against its own delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q    <= 1'b0;
      avail_prev <= 1'b0;
    end else begin
      avail_q    <= core_avail;
      avail_prev <= avail_q;
    end
  end

  assign push_req = avail_q && !avail_prev;

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (rd_data),
    .din   (core_byte),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ovr_set = push_req && fifo_full && !rd_data;

  // A fresh overrun beats the clear-on-read from a simultaneous status read.
  always_ff @(posedge clk) begin
    if (reset)          overrun <= 1'b0;
    else if (ovr_set)   overrun <= 1'b1;
    else if (rd_status) overrun <= 1'b0;
  end

  assign status_byte = make_status(!fifo_empty, fifo_full, overrun, !core_ready);

  always_ff @(posedge clk) begin
    if (reset)          dout <= 8'h00;
    else if (rd_status) dout <= status_byte;
    else if (rd_data)   dout <= fifo_empty ? EMPTY_READ : fifo_head;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based reference model compared
// every cycle, plus hand-computed literal checks from the directed scenarios.
module tb_uart_rx_ctrl;

  localparam int CLK_DIV = 15;
  localparam int DEPTH   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       core_rxIN;
  logic       core_tick;
  logic [7:0] core_byte;
  logic       core_ready;
  logic       core_avail;
  logic       rd_data;
  logic       rd_status;
  logic [7:0] dout;

  int compared   = 0;
  int mismatched = 0;

  uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .core_rxIN  (core_rxIN),
    .core_tick  (core_tick),
    .core_byte  (core_byte),
    .core_ready (core_ready),
    .core_avail (core_avail),
    .rd_data    (rd_data),
    .rd_status  (rd_status),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, the read port a priority choice.
  logic [7:0] m_q[$];
  logic       m_ovr;
  logic [7:0] m_dout;
  logic       m_tick;
  int         m_cyc;
  logic       h1, h2, r1, r2;
  bit         m_valid = 0;

  always @(posedge clk) begin
    logic [7:0] st, popped;
    logic       push, newovr;
    if (reset) begin
      m_q.delete();
      m_ovr = 0; m_dout = 8'h00; m_cyc = 1; m_tick = 0;
      h1 = 0; h2 = 0; r1 = 1; r2 = 1; m_valid = 1;
    end else if (m_valid) begin
      m_cyc++;
      push = h1 && !h2;
      h2 = h1; h1 = core_avail;
      r2 = r1; r1 = rxd;
      st = {4'b0, ~core_ready, m_ovr, m_q.size() == DEPTH, m_q.size() != 0};
      popped = 8'hFF;
      if (rd_data && m_q.size() != 0) popped = m_q.pop_front();
      newovr = 0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(core_byte);
        else newovr = 1;
      end
      if (newovr) m_ovr = 1;
      else if (rd_status) m_ovr = 0;
      if (rd_status) m_dout = st;
      else if (rd_data) m_dout = popped;
      m_tick = ((m_cyc % CLK_DIV) == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_dout", dout, m_dout);
      checkOutput("model_tick", {7'b0, core_tick}, {7'b0, m_tick});
      checkOutput("model_rxin", {7'b0, core_rxIN}, {7'b0, r2});
    end
  end

  task automatic applyStimulus(input logic d, input logic s, input logic [7:0] exp, input string name);
    @(negedge clk); rd_data = d; rd_status = s;
    @(negedge clk); rd_data = 0; rd_status = 0;
    checkOutput(name, dout, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic pop, input logic [7:0] exp_pop);
    @(negedge clk); core_byte = b; core_avail = 1;
    @(negedge clk); rd_data = pop;
    @(negedge clk); rd_data = 0;
    if (pop) checkOutput("push_with_pop", dout, exp_pop);
    @(negedge clk); core_avail = 0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first, ticks;
    reset = 1; rxd = 1; core_byte = 0; core_ready = 1; core_avail = 0;
    rd_data = 0; rd_status = 0;
    repeat (3) @(negedge clk);
    reset = 0;

    first = 0; ticks = 0;
    for (int i = 1; i <= 100; i++) begin
      if (core_tick) begin
        if (first == 0) first = i;
        ticks++;
      end
      @(negedge clk);
    end
    checkOutput("first_tick_cycle", 8'(first), 8'd15);
    checkOutput("tick_count_100", 8'(ticks), 8'd6);
    checkOutput("idle_dout", dout, 8'h00);
    applyStimulus(0, 1, 8'h00, "idle_status");

    @(negedge clk); core_byte = 8'hA5; core_avail = 1;
    repeat (500) @(negedge clk);
    core_avail = 0;
    @(negedge clk);
    applyStimulus(0, 1, 8'h01, "a5_status");
    applyStimulus(1, 0, 8'hA5, "a5_data");
    applyStimulus(0, 1, 8'h00, "a5_status_after");

    for (int i = 0; i < 9; i++) push_byte(8'(i), 0, 8'h00);
    applyStimulus(0, 1, 8'h07, "overrun_status");
    applyStimulus(0, 1, 8'h03, "overrun_cleared");
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(i), "drain");
    applyStimulus(1, 0, 8'hFF, "empty_read");

    for (int i = 0; i < 8; i++) push_byte(8'(i), 0, 8'h00);
    push_byte(8'h55, 1, 8'h00);
    applyStimulus(0, 1, 8'h03, "full_pushpop_status");
    for (int i = 1; i < 8; i++) applyStimulus(1, 0, 8'(i), "drain2");
    applyStimulus(1, 0, 8'h55, "last_is_55");
    applyStimulus(0, 1, 8'h00, "drain2_status");

    push_byte(8'h3C, 0, 8'h00);
    applyStimulus(1, 1, 8'h01, "both_strobes");
    applyStimulus(0, 1, 8'h00, "both_then_empty");

    push_byte(8'h77, 1, 8'hFF);
    applyStimulus(0, 1, 8'h01, "empty_pushpop_status");
    applyStimulus(1, 0, 8'h77, "empty_pushpop_data");

    repeat (3) @(negedge clk);
    rxd = 0;
    @(negedge clk);
    checkOutput("rxin_one_cycle", {7'b0, core_rxIN}, 8'h01);
    @(negedge clk);
    checkOutput("rxin_two_cycles", {7'b0, core_rxIN}, 8'h00);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); rxd = 1'($urandom_range(0, 1));
    end

    for (int i = 0; i < 3; i++) push_byte(8'h90 + 8'(i), 0, 8'h00);
    core_ready = 0; rxd = 0;
    applyStimulus(0, 1, 8'h09, "busy_status");
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; core_ready = 1;
    checkOutput("reset_dout", dout, 8'h00);
    checkOutput("reset_rxin", {7'b0, core_rxIN}, 8'h01);
    rxd = 1;
    applyStimulus(0, 1, 8'h00, "reset_status");
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
